// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM stage: funct3 size codes, FSM states and timeout sizing.
package pipeline_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

   function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return off[0];
         default:     return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/replication and load extract/extend.
module mem_lane_align
   import pipeline_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   logic [1:0]  w_off;
   logic [31:0] w_shifted;

   always_comb begin
      w_off   = '0;
      o_be    = '1;
      o_wdata = i_store_data;
      // Offset bits finer than the access size are dropped (H keeps addr[1], W uses lane 0).
      case (i_funct3)
         F3_B, F3_BU: begin
            w_off   = i_off;
            o_be    = 4'b0001 << w_off;
            o_wdata = {4{i_store_data[7:0]}};
         end
         F3_H, F3_HU: begin
            w_off   = {i_off[1], 1'b0};
            o_be    = 4'b0011 << w_off;
            o_wdata = {2{i_store_data[15:0]}};
         end
         F3_W:    ;
         default: ;
      endcase

      w_shifted = i_rdata >> {w_off, 3'b000};
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_BU:   o_load_data = {24'd0, w_shifted[7:0]};
         F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_HU:   o_load_data = {16'd0, w_shifted[15:0]};
         default: o_load_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access with timeout, load alignment and MEM/WB registers.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses complete without a request, flagged misalign_out.
module mem_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  rd_in,
   input  logic        reg_write_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [2:0]  funct3_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        out_valid,
   output logic [31:0] alu_result_out,
   output logic [31:0] mem_data_out,
   output logic [4:0]  rd_out,
   output logic        reg_write_out,
   output logic        bus_err_out,
   output logic        misalign_out
);

   localparam int unsigned CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_alu;
   logic [4:0]       r_rd;
   logic             r_rw;
   logic             r_load;
   logic [2:0]       r_f3;
   logic             r_req, r_we;
   logic [31:0]      r_addr, r_wdata;
   logic [3:0]       r_be;
   logic             r_out_valid, r_out_rw, r_out_berr, r_out_mis;
   logic [31:0]      r_out_alu, r_out_mdata;
   logic [4:0]       r_out_rd;

   logic        w_memop, w_trap, w_timeout;
   logic [2:0]  w_lane_f3;
   logic [1:0]  w_lane_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load_data;

   assign w_memop   = mem_read_in | mem_write_in;
   assign w_timeout = (r_state == ACCESS) && (r_cnt == CNT_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap = w_memop & is_misaligned(funct3_in, alu_result_in[1:0]);
`else
   assign w_trap = 1'b0;
`endif

   // One aligner serves both directions: store lanes from the live inputs while IDLE,
   // load extraction from the latched size/offset while ACCESS.
   assign w_lane_f3  = (r_state == IDLE) ? funct3_in : r_f3;
   assign w_lane_off = (r_state == IDLE) ? alu_result_in[1:0] : r_alu[1:0];

   mem_lane_align u_align (
      .i_funct3     (w_lane_f3),
      .i_off        (w_lane_off),
      .i_store_data (store_data_in),
      .i_rdata      (dmem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data)
   );

   always_comb begin
      stall_out = 1'b0;
      if (reset) begin
         case (r_state)
            IDLE:    stall_out = in_valid & w_memop & ~w_trap;
            ACCESS:  stall_out = ~dmem_ack & ~w_timeout;
            default: stall_out = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_alu       <= '0;
         r_rd        <= '0;
         r_rw        <= 1'b0;
         r_load      <= 1'b0;
         r_f3        <= '0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_out_valid <= 1'b0;
         r_out_alu   <= '0;
         r_out_mdata <= '0;
         r_out_rd    <= '0;
         r_out_rw    <= 1'b0;
         r_out_berr  <= 1'b0;
         r_out_mis   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_rw    <= 1'b0;
         r_out_mdata <= '0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (!w_memop || w_trap) begin
                     r_out_valid <= 1'b1;
                     r_out_alu   <= alu_result_in;
                     r_out_rd    <= rd_in;
                     r_out_rw    <= reg_write_in & ~w_trap;
                     r_out_berr  <= 1'b0;
                     r_out_mis   <= w_trap;
                  end else begin
                     r_state <= ACCESS;
                     r_cnt   <= '0;
                     r_alu   <= alu_result_in;
                     r_rd    <= rd_in;
                     r_rw    <= reg_write_in;
                     r_load  <= mem_read_in & ~mem_write_in;
                     r_f3    <= funct3_in;
                     r_req   <= 1'b1;
                     r_we    <= mem_write_in;
                     r_addr  <= {alu_result_in[31:2], 2'b00};
                     r_wdata <= w_wdata;
                     r_be    <= w_be;
                  end
               end
            end
            ACCESS: begin
               if (dmem_ack || w_timeout) begin
                  r_state     <= IDLE;
                  r_req       <= 1'b0;
                  r_we        <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out_alu   <= r_alu;
                  r_out_rd    <= r_rd;
                  r_out_rw    <= r_rw & dmem_ack;
                  r_out_mdata <= (dmem_ack && r_load) ? w_load_data : '0;
                  r_out_berr  <= ~dmem_ack;
                  r_out_mis   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign dmem_req       = r_req;
   assign dmem_we        = r_we;
   assign dmem_addr      = r_addr;
   assign dmem_wdata     = r_wdata;
   assign dmem_be        = r_be;
   assign out_valid      = r_out_valid;
   assign alu_result_out = r_out_alu;
   assign mem_data_out   = r_out_mdata;
   assign rd_out         = r_out_rd;
   assign reg_write_out  = r_out_rw;
   assign bus_err_out    = r_out_berr;
   assign misalign_out   = r_out_mis;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register feeding writeback. It issues loads and stores to the data memory over a req/ack handshake and stalls upstream while an access is outstanding. It also aligns and extends load data and registers the writeback fields: ALU result, memory data, destination register and write enable.

## Interface
- TIMEOUT_CYCLES, 255: cycles in ACCESS without dmem_ack before the access aborts as a bus error.
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  EX/MEM slot holds an instruction.
- alu_result_in  input  32  ALU result, which is the effective address for memory ops.
- store_data_in  input  32  rs2 value for stores.
- rd_in  input  5  destination register.
- reg_write_in  input  1  instruction writes rd.
- mem_read_in  input  1  load.
- mem_write_in  input  1  store.
- funct3_in  input  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- stall_out  output  1  upstream must hold its inputs this cycle.
- dmem_req  output  1  access request.
- dmem_we  output  1  request is a write.
- dmem_addr  output  32  word address, with bits [1:0] forced to 0.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_ack  input  1  one-cycle completion strobe.
- dmem_rdata  input  32  read word, valid with dmem_ack.
- out_valid  output  1  writeback fields are valid.
- alu_result_out  output  32  registered ALU result.
- mem_data_out  output  32  extended load data; 0 for every non-load.
- rd_out  output  5  registered rd.
- reg_write_out  output  1  registered write enable, gated by errors.
- bus_err_out  output  1  access timed out.
- misalign_out  output  1  misaligned access trapped.

## Operation
- States are IDLE and ACCESS.
- **IDLE, in_valid with no memory op:** the instruction is registered to the outputs at the next edge. stall_out stays 0.
- **IDLE, in_valid with a memory op:** stall_out is 1 combinationally. The fields are latched into internal registers and the state moves to ACCESS.
- **ACCESS:**
  - dmem_req and dmem_we come from registers and are held stable until dmem_ack.
  - stall_out is 1 while dmem_ack is low.
  - In the ack cycle stall_out drops, so upstream advances at that edge.
  - The outputs update at that edge and the state returns to IDLE.
- **Both mem_read_in and mem_write_in set:** treated as a store. mem_data_out is 0.
- **Lanes (little-endian), with off = addr[1:0]:**
  - SB: be = 0001<<off, wdata = byte×4.
  - SH: be = 0011<<(off&2), wdata = half×2.
  - SW: be = 1111.
  - Loads: rdata is shifted right by 8*off, then B/H sign-extend and BU/HU zero-extend.
- **Timeout:** the counter resets on entering ACCESS. When it reaches TIMEOUT_CYCLES:
  - dmem_req drops and the state returns to IDLE.
  - The outputs update with bus_err_out=1, reg_write_out=0, mem_data_out=0.
- **Late ack:** a dmem_ack arriving while in IDLE is ignored.
- **No valid instruction:** in cycles where no instruction completes, out_valid=0, reg_write_out=0 and mem_data_out=0. The other outputs hold their values.

## Timing
- Reset (asynchronous):
  - State returns to IDLE and the timeout counter clears.
  - dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata are 0.
  - All outputs are 0, including stall_out (combinationally, from IDLE).
  - An access in flight when reset arrives is abandoned.
- Non-memory op: 1 cycle from input to output.
- Memory op:
  - Presented in cycle 0, dmem_req rises in cycle 1.
  - Ack in cycle k≥1 gives outputs valid in cycle k+1, so the minimum latency is 2.
- Back-to-back memory ops: each enters IDLE→ACCESS, leaving one IDLE cycle between requests.

## Configuration
- MEM_MISALIGN_TRAP_EN
- **Defined:**
  - H with addr[0]=1, or W with addr[1:0]≠0, issues no request and completes at the next edge.
  - That completion has misalign_out=1, reg_write_out=0 and mem_data_out=0, and stall_out stays 0.
- **Undefined:**
  - Low address bits beyond the access size are ignored: H uses addr[1] only, W uses offset 0.
  - misalign_out is tied 0.

## Structure
- pipeline_pkg holds the funct3 size encodings, the state enum (IDLE, ACCESS) and the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- Sub-module mem_lane_align is combinational. It generates be/wdata from size, offset and store data, and extracts and extends load data from rdata.

## Test plan
- **ALU op:** rd=5, result 0x1234, reg_write=1 → next cycle out_valid=1, alu_result_out=0x1234, mem_data_out=0, stall_out never high.
- **LB:** addr 0x103, rdata 0x80FF_0000 acked in cycle 1 → dmem_addr 0x100, mem_data_out 0xFFFF_FF80 in cycle 2.
- **SH:** addr 0x202, data 0xABCD → be=1100, wdata 0xABCD_ABCD, we=1, mem_data_out=0.
- **Ack delay:** ack after 3 cycles → stall_out high for 3 cycles, req stable throughout. No ack for 255 cycles → bus_err_out=1, reg_write_out=0, then IDLE.
- **Misaligned LW at 0x101:** with MEM_MISALIGN_TRAP_EN → no dmem_req, misalign_out=1. Without it → access at 0x100, be=1111.
- **Reset in ACCESS:** reset low while in ACCESS → dmem_req 0 immediately, all outputs 0. A subsequent stray ack produces no output.
